// File: rtl/iitb_pkg.sv
// Shared IITB-RISC pipeline definitions: fetch FSM encodings, IF/ID bundle
// field positions and a bundle construction helper.
package iitb_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

  localparam int BND_INSTR_MSB = 40;
  localparam int BND_INSTR_LSB = 25;
  localparam int BND_PC_MSB    = 24;
  localparam int BND_PC_LSB    = 9;
  localparam int BND_VALID     = 0;

  localparam logic [40:0] BUBBLE = 41'd0;

  // Build a valid IF/ID bundle: {instruction, its pc, 8 zero bits, valid}
  function automatic logic [40:0] make_bundle(input logic [15:0] instr,
                                              input logic [15:0] pc);
    return {instr, pc, 8'd0, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter for the fetch stage. Priority: reset, redirect, increment.
// o_pc_nxt exposes the value the register will take at the next edge so the
// top can register the memory address in step with the pc.
module fetch_pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_inc,
  output logic [15:0] o_pc,
  output logic [15:0] o_pc_nxt
);

  logic [15:0] r_pc;

  // Next-pc select: redirect wins over sequential increment (wraps at 16 bits)
  always_comb begin
    o_pc_nxt = r_pc;
    if (i_redirect) begin
      o_pc_nxt = i_redirect_pc;
    end else if (i_inc) begin
      o_pc_nxt = r_pc + 16'd1;
    end else begin
      o_pc_nxt = r_pc;
    end
  end

  // PC state register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= o_pc_nxt;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch FSM, hold buffer and IF/ID bundle register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import iitb_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        should_stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [40:0] instr_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  fetch_state_e r_state, w_state_nxt;
  logic [40:0]  r_instr, w_instr_nxt;
  logic [15:0]  r_hold_instr, w_hold_instr_nxt;
  logic [15:0]  r_hold_pc, w_hold_pc_nxt;
  logic         r_req, w_req_nxt;
  logic [15:0]  r_addr, w_addr_nxt;
  logic [15:0]  w_pc, w_pc_nxt;
  logic         w_inc;
  logic         w_slot_free;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk          (clk),
    .rst          (rst),
    .i_redirect   (redirect_valid),
    .i_redirect_pc(redirect_pc),
    .i_inc        (w_inc),
    .o_pc         (w_pc),
    .o_pc_nxt     (w_pc_nxt)
  );

  // The bundle slot can take new data unless decode is stalled on a valid bundle
  assign w_slot_free = !should_stall || !r_instr[BND_VALID];

  // Next-state and datapath selection; redirect has priority in every state
  always_comb begin
    w_state_nxt      = r_state;
    w_instr_nxt      = should_stall ? r_instr : BUBBLE;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc_nxt    = r_hold_pc;
    w_inc            = 1'b0;
    if (redirect_valid) begin
      w_instr_nxt = BUBBLE;
      // A request still waiting for its ack must be drained at the old address
      if (((r_state == FETCH_REQ) || (r_state == FETCH_DRAIN)) && !imem_ack) begin
        w_state_nxt = FETCH_DRAIN;
      end else begin
        w_state_nxt = FETCH_REQ;
      end
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          w_state_nxt = FETCH_REQ;
        end
        FETCH_REQ: begin
          if (imem_ack) begin
            w_inc = 1'b1;
            if (w_slot_free) begin
              w_instr_nxt = make_bundle(imem_rdata, w_pc);
              w_state_nxt = FETCH_REQ;
            end else begin
              w_hold_instr_nxt = imem_rdata;
              w_hold_pc_nxt    = w_pc;
              w_state_nxt      = FETCH_HOLD;
            end
          end else begin
            w_state_nxt = FETCH_REQ;
          end
        end
        FETCH_HOLD: begin
          if (!should_stall) begin
            w_instr_nxt = make_bundle(r_hold_instr, r_hold_pc);
            w_state_nxt = FETCH_REQ;
          end else begin
            w_state_nxt = FETCH_HOLD;
          end
        end
        FETCH_DRAIN: begin
          // Drained word is discarded; refetch starts at the redirected pc
          if (imem_ack) begin
            w_state_nxt = FETCH_REQ;
          end else begin
            w_state_nxt = FETCH_DRAIN;
          end
        end
        default: begin
          w_state_nxt = FETCH_IDLE;
        end
      endcase
    end
    w_req_nxt  = (w_state_nxt == FETCH_REQ) || (w_state_nxt == FETCH_DRAIN);
    w_addr_nxt = (w_state_nxt == FETCH_DRAIN) ? r_addr : w_pc_nxt;
  end

  // FSM, bundle, hold buffer and registered memory request outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FETCH_IDLE;
      r_instr      <= BUBBLE;
      r_hold_instr <= 16'h0000;
      r_hold_pc    <= 16'h0000;
      r_req        <= 1'b0;
      r_addr       <= RESET_PC;
    end else begin
      r_state      <= w_state_nxt;
      r_instr      <= w_instr_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_req        <= w_req_nxt;
      r_addr       <= w_addr_nxt;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign instr_out = r_instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic        w_fetch_evt;
  logic        w_stall_evt;

  assign w_fetch_evt = !redirect_valid &&
                       (((r_state == FETCH_REQ) && imem_ack && w_slot_free) ||
                        ((r_state == FETCH_HOLD) && !should_stall));
  assign w_stall_evt = should_stall && r_instr[BND_VALID];

  // Saturating counters for valid bundles loaded and stalled-valid cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= 32'd0;
      r_perf_stall   <= 32'd0;
    end else begin
      if (w_fetch_evt && (r_perf_fetched != 32'hFFFF_FFFF)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_stall_evt && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the IITB-RISC pipeline, directly upstream of `decode`. It owns the program counter, issues word requests to instruction memory over a req/ack handshake, and drives the 41-bit IF/ID bundle that `decode` consumes. It honours `should_stall` from the hazard detection unit and squashes on redirects from later stages. With zero-wait memory it sustains one instruction per cycle.

## Interface
- `RESET_PC`, 16'h0000, PC loaded on reset
- `clk`  in  1  pipeline clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  request valid
- `imem_addr`  out  16  word address; stable while `imem_req` high and `imem_ack` not yet seen
- `imem_rdata`  in  16  instruction word; valid in the cycle `imem_ack` is high
- `imem_ack`  in  1  request completes at this edge (may be high in the first `imem_req` cycle)
- `should_stall`  in  1  hold the IF/ID bundle (same signal `decode` receives)
- `redirect_valid`  in  1  branch/jump resolved; squash and refetch
- `redirect_pc`  in  16  new fetch address
- `instr_out`  out  41  IF/ID bundle: [40:25] instruction, [24:9] its PC, [8:1] zero, [0] valid
- `perf_fetched`, `perf_stall`  out  32 each  only with `FETCH_PERF_CNT_EN`

## Operation
- **IDLE:** one cycle after reset release; `imem_req`=0. Next state: REQ.
- **REQ:** `imem_req`=1, `imem_addr`=pc. On ack:
  - If the bundle slot is free (`!should_stall` or `instr_out[0]`=0), load {rdata, pc, 8'd0, 1'b1}, set pc ← pc+1, stay in REQ.
  - Otherwise capture into the hold buffer {rdata, pc}, set pc ← pc+1, go to HOLD.
- **HOLD:** `imem_req`=0. When `should_stall`=0, move the hold buffer into `instr_out` and go to REQ.
- **DRAIN:** entered on a redirect while a request is outstanding (REQ with no ack). Keep `imem_req`=1 with the old address until ack, discard the data, then go to REQ at the new pc.
- **Redirect** has the highest priority in every state:
  - `instr_out` ← 41'd0, hold buffer invalidated, pc ← `redirect_pc`.
  - Redirect together with ack: discard the data and go directly to REQ.
  - Redirect during HOLD or IDLE: go to REQ.
  - Redirect overrides `should_stall`.
- **Stall without ack or redirect:** `instr_out` holds its value bit-exact.
- **No stall and no instruction loaded this cycle:** `instr_out` ← 41'd0 (bubble, valid=0).
- **PC arithmetic:** 16-bit, word-addressed, +1 per instruction; 16'hFFFF wraps to 16'h0000 with no flag.

## Timing
- **Reset values:** `instr_out`=41'd0, `imem_req`=0, `imem_addr`=`RESET_PC`, pc=`RESET_PC`, state=IDLE, perf counters 0.
- **Reset mid-operation:** all state clears at once and any outstanding request is abandoned. Memory must tolerate `imem_req` dropping without ack on reset.
- **Request timing:** the first `imem_req` is asserted 1 cycle after reset deassertion.
- **Latency:** the edge sampling `imem_ack` loads `instr_out`, so data is visible in the next cycle.
- **Throughput:** with ack tied high, one valid bundle per cycle.
- **Redirect:** `redirect_valid` sampled at edge N ⇒ `instr_out` bubble after N and `imem_addr`=`redirect_pc` after N. In DRAIN, the new address appears the cycle after the draining ack.

## Configuration
- **`FETCH_PERF_CNT_EN` defined:**
  - `perf_fetched` counts bundles loaded with valid=1.
  - `perf_stall` counts cycles with `should_stall`=1 and `instr_out[0]`=1.
  - Both are 32-bit, saturating at 32'hFFFFFFFF, and reset to 0.
- **Undefined:** ports and counters are absent; all other behaviour is identical.

## Structure
- **Shared package `iitb_pkg`:**
  - `FETCH_IDLE`/`FETCH_REQ`/`FETCH_HOLD`/`FETCH_DRAIN` state encodings (2-bit).
  - Bundle field positions (`BND_INSTR_MSB`=40, `BND_PC_LSB`=9, `BND_VALID`=0).
  - `BUBBLE`=41'd0.
- **Sub-module `fetch_pc_reg`:** PC register with reset/redirect/increment priority mux. The FSM, hold buffer and bundle register live in the top.

## Test plan
- **Zero-wait streaming:** ack tied 1, `imem_rdata`=16'h1000+addr, `RESET_PC`=0 ⇒ bundles for PC 0,1,2,3 on consecutive cycles, valid=1, [40:25]=16'h1000..16'h1003.
- **Wait-state memory:** ack 2 cycles after req ⇒ `imem_addr` stable for 3 cycles, one bundle per 3 cycles, bubbles (41'd0) between them.
- **Stall with pending ack:** `should_stall`=1 for 4 cycles with the bundle at PC 5 valid, ack arrives for PC 6 ⇒ HOLD and `imem_req`=0. After release: PC 6 bundle next cycle, then a request for PC 7.
- **Redirect in DRAIN:** redirect to 16'h0040 one cycle before ack ⇒ the acked word is discarded, `instr_out`=0, the next request is at 16'h0040. Also assert redirect with ack in the same cycle ⇒ no DRAIN cycle.
- **Boundary cases:**
  - pc=16'hFFFF fetch ⇒ next `imem_addr`=16'h0000.
  - `rst` pulsed mid-request ⇒ `imem_req`=0 and `instr_out`=0 immediately, with no clock edge needed.
- **With `FETCH_PERF_CNT_EN`:** 10 fetches and 3 stalled-valid cycles ⇒ `perf_fetched`=10, `perf_stall`=3.
